// File: rtl/snake_core_param.sv
// Snake game engine: body, direction, apple placement with occupancy retry, score and end states.
// Segments and apple are packed {y[3:0],x[3:0]}; unused segment slots read 8'hFF.
module snake_core_param #(
  parameter int         GRID_W     = 10,
  parameter int         GRID_H     = 10,
  parameter int         MAX_LEN    = 9,
  parameter int         INIT_LEN   = 3,
  parameter int         START_X    = 4,
  parameter int         START_Y    = 5,
  parameter logic [7:0] APPLE_INIT = 8'h57,
  parameter bit         WRAP_MODE  = 1'b0,
  parameter int         SCORE_W    = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   tick,
  input  logic                   up,
  input  logic                   right,
  input  logic                   left,
  input  logic                   down,
  input  logic [3:0]             rnd_x,
  input  logic [3:0]             rnd_y,
  output logic [MAX_LEN*8-1:0]   snake,
  output logic [7:0]             apple,
  output logic [4:0]             len,
  output logic [SCORE_W-1:0]     score,
  output logic                   score_flag,
  output logic                   dead_flag,
  output logic                   win_flag,
  output logic                   new_rnd
);

  // state   | meaning
  // S_IDLE  | waiting for first non-left press
  // S_RUN   | snake moves on each tick
  // S_PLACE | searching for a free apple cell, ticks dropped
  // S_DEAD  | collision, everything frozen
  // S_WIN   | reached MAX_LEN, everything frozen
  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PLACE, S_DEAD, S_WIN} state_t;
  // Encoding chosen so the reverse direction is the bitwise inverse.
  typedef enum logic [1:0] {D_UP = 2'd0, D_RIGHT = 2'd1, D_LEFT = 2'd2, D_DOWN = 2'd3} dir_t;

  localparam logic [3:0] X_MAX = 4'(GRID_W - 1);
  localparam logic [3:0] Y_MAX = 4'(GRID_H - 1);

  state_t               state, state_nxt;
  dir_t                 dir, dir_nxt, pend_dir, pend_nxt, btn_dir;
  logic [7:0]           seg     [MAX_LEN];
  logic [7:0]           seg_nxt [MAX_LEN];
  logic [7:0]           apple_nxt, nh, cand;
  logic [4:0]           len_nxt, new_len;
  logic [SCORE_W-1:0]   score_nxt;
  logic                 score_flag_nxt;
  logic [3:0]           hx, hy, nx, ny;
  logic                 btn_ok, oob, hit, eat, place_ok;

  assign hx = seg[0][3:0];
  assign hy = seg[0][7:4];

  always_comb begin
    state_nxt      = state;
    dir_nxt        = dir;
    pend_nxt       = pend_dir;
    seg_nxt        = seg;
    apple_nxt      = apple;
    len_nxt        = len;
    new_len        = len;
    score_nxt      = score;
    score_flag_nxt = 1'b0;
    nx             = hx;
    ny             = hy;
    oob            = 1'b0;
    hit            = 1'b0;
    place_ok       = 1'b1;

    if (up)         btn_dir = D_UP;
    else if (right) btn_dir = D_RIGHT;
    else if (left)  btn_dir = D_LEFT;
    else            btn_dir = D_DOWN;
    btn_ok = (up | right | left | down) && (btn_dir != dir_t'(~dir));

    case (pend_dir)
      D_UP:    begin oob = (hy == 4'd0);  ny = oob ? Y_MAX : hy - 4'd1; end
      D_DOWN:  begin oob = (hy == Y_MAX); ny = oob ? 4'd0  : hy + 4'd1; end
      D_LEFT:  begin oob = (hx == 4'd0);  nx = oob ? X_MAX : hx - 4'd1; end
      default: begin oob = (hx == X_MAX); nx = oob ? 4'd0  : hx + 4'd1; end
    endcase
    nh  = {ny, nx};
    eat = (nh == apple);

    // The tail cell is vacated by the move unless the snake grows this step.
    for (int i = 1; i < MAX_LEN; i++) begin
      if (seg[i] == nh) begin
        if (i < int'(len) - 1)                hit = 1'b1;
        else if (i == int'(len) - 1 && eat)   hit = 1'b1;
      end
    end

    cand = {rnd_y, rnd_x};
    if ({1'b0, rnd_x} >= 5'(GRID_W) || {1'b0, rnd_y} >= 5'(GRID_H)) place_ok = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i < int'(len) && seg[i] == cand) place_ok = 1'b0;
    end

    case (state)
      S_IDLE: begin
        if (btn_ok) begin
          pend_nxt  = btn_dir;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (btn_ok) pend_nxt = btn_dir;
        if (tick) begin
          dir_nxt = pend_dir;
          if ((oob && !WRAP_MODE) || hit) begin
            state_nxt = S_DEAD;
          end else begin
            new_len    = eat ? len + 5'd1 : len;
            len_nxt    = new_len;
            seg_nxt[0] = nh;
            for (int i = 1; i < MAX_LEN; i++)
              seg_nxt[i] = (i < int'(new_len)) ? seg[i-1] : 8'hFF;
            if (eat) begin
              score_nxt      = (score == '1) ? score : score + 1'b1;
              score_flag_nxt = 1'b1;
              state_nxt      = (new_len == 5'(MAX_LEN)) ? S_WIN : S_PLACE;
            end
          end
        end
      end
      S_PLACE: begin
        if (btn_ok) pend_nxt = btn_dir;
        if (place_ok) begin
          apple_nxt = cand;
          state_nxt = S_RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      dir        <= D_RIGHT;
      pend_dir   <= D_RIGHT;
      for (int i = 0; i < MAX_LEN; i++)
        seg[i] <= (i < INIT_LEN) ? {4'(START_Y), 4'(START_X - i)} : 8'hFF;
      apple      <= APPLE_INIT;
      len        <= 5'(INIT_LEN);
      score      <= '0;
      score_flag <= 1'b0;
      dead_flag  <= 1'b0;
      win_flag   <= 1'b0;
      new_rnd    <= 1'b0;
    end else begin
      state      <= state_nxt;
      dir        <= dir_nxt;
      pend_dir   <= pend_nxt;
      seg        <= seg_nxt;
      apple      <= apple_nxt;
      len        <= len_nxt;
      score      <= score_nxt;
      score_flag <= score_flag_nxt;
      dead_flag  <= (state_nxt == S_DEAD);
      win_flag   <= (state_nxt == S_WIN);
      new_rnd    <= (state_nxt == S_PLACE);
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign snake[8*g +: 8] = seg[g];
  end

endmodule

// File: tb/tb_snake_core_param.sv
// Directed bench for snake_core_param: default wall instance, a wrap instance and a MAX_LEN=4 instance share stimulus.
module tb_snake_core_param;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic up = 1'b0, right = 1'b0, left = 1'b0, down = 1'b0;
  logic [3:0] rnd_x = 4'hF, rnd_y = 4'hF;

  logic [71:0] snake_a, snake_w;
  logic [31:0] snake_v;
  logic [7:0]  apple_a, apple_w, apple_v;
  logic [4:0]  len_a, len_w, len_v;
  logic [3:0]  score_a, score_w, score_v;
  logic sflag_a, dead_a, win_a, nrnd_a;
  logic sflag_w, dead_w, win_w, nrnd_w;
  logic sflag_v, dead_v, win_v, nrnd_v;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  snake_core_param dut (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .right(right), .left(left), .down(down),
    .rnd_x(rnd_x), .rnd_y(rnd_y), .snake(snake_a), .apple(apple_a), .len(len_a), .score(score_a),
    .score_flag(sflag_a), .dead_flag(dead_a), .win_flag(win_a), .new_rnd(nrnd_a));

  snake_core_param #(.WRAP_MODE(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .right(right), .left(left), .down(down),
    .rnd_x(rnd_x), .rnd_y(rnd_y), .snake(snake_w), .apple(apple_w), .len(len_w), .score(score_w),
    .score_flag(sflag_w), .dead_flag(dead_w), .win_flag(win_w), .new_rnd(nrnd_w));

  snake_core_param #(.MAX_LEN(4)) dut_win (
    .clk(clk), .rst(rst), .tick(tick), .up(up), .right(right), .left(left), .down(down),
    .rnd_x(rnd_x), .rnd_y(rnd_y), .snake(snake_v), .apple(apple_v), .len(len_v), .score(score_v),
    .score_flag(sflag_v), .dead_flag(dead_v), .win_flag(win_v), .new_rnd(nrnd_v));

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; tick = 1'b0; up = 1'b0; right = 1'b0; left = 1'b0; down = 1'b0;
    rnd_x = 4'hF; rnd_y = 4'hF;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic press(input logic u, input logic r, input logic l, input logic d);
    @(negedge clk);
    up = u; right = r; left = l; down = d;
    @(negedge clk);
    up = 1'b0; right = 1'b0; left = 1'b0; down = 1'b0;
  endtask

  task automatic step();
    @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  // Present one apple candidate for a single clock.
  task automatic offer(input logic [3:0] x, input logic [3:0] y);
    rnd_x = x; rnd_y = y;
    @(negedge clk);
    rnd_x = 4'hF; rnd_y = 4'hF;
  endtask

  task automatic test_reset();
    checks++; if (snake_a[23:0] !== 24'h525354) begin failures++; $display("FAIL reset_body got=%h exp=%h", snake_a[23:0], 24'h525354); end
    checks++; if (snake_a[71:24] !== {6{8'hFF}}) begin failures++; $display("FAIL reset_unused got=%h exp=%h", snake_a[71:24], {6{8'hFF}}); end
    checks++; if (len_a !== 5'd3) begin failures++; $display("FAIL reset_len got=%0d exp=3", len_a); end
    checks++; if (apple_a !== 8'h57) begin failures++; $display("FAIL reset_apple got=%h exp=57", apple_a); end
    checks++; if ({score_a, sflag_a, dead_a, win_a, nrnd_a} !== 8'h00) begin failures++; $display("FAIL reset_flags got=%h exp=00", {score_a, sflag_a, dead_a, win_a, nrnd_a}); end
    press(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checks++; if (snake_a[23:0] !== 24'h525354 || dead_a !== 1'b0) begin failures++; $display("FAIL idle_left_ignored got=%h dead=%b exp=525354 dead=0", snake_a[23:0], dead_a); end
  endtask

  task automatic test_reset_mid_run();
    apply_reset();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (snake_a[31:0] !== 32'hFF535455) begin failures++; $display("FAIL first_move got=%h exp=FF535455", snake_a[31:0]); end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (snake_a[23:0] !== 24'h525354) begin failures++; $display("FAIL midrst_body got=%h exp=525354", snake_a[23:0]); end
    checks++; if (snake_a[31:24] !== 8'hFF) begin failures++; $display("FAIL midrst_seg3 got=%h exp=FF", snake_a[31:24]); end
    checks++; if (len_a !== 5'd3 || score_a !== 4'd0 || apple_a !== 8'h57) begin failures++; $display("FAIL midrst_state got=len%0d score%0d apple%h exp=len3 score0 apple57", len_a, score_a, apple_a); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_eat_place();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (snake_a[7:0] !== 8'h55) begin failures++; $display("FAIL eat_head1 got=%h exp=55", snake_a[7:0]); end
    step();
    checks++; if (snake_a[7:0] !== 8'h56) begin failures++; $display("FAIL eat_head2 got=%h exp=56", snake_a[7:0]); end
    step();
    checks++; if (snake_a[39:0] !== 40'hFF54555657) begin failures++; $display("FAIL eat_body got=%h exp=FF54555657", snake_a[39:0]); end
    checks++; if ({len_a, score_a, sflag_a, nrnd_a} !== {5'd4, 4'd1, 1'b1, 1'b1}) begin failures++; $display("FAIL eat_flags got=len%0d score%0d sf%b nr%b exp=len4 score1 sf1 nr1", len_a, score_a, sflag_a, nrnd_a); end
    rnd_x = 4'd4; rnd_y = 4'd5;
    @(negedge clk);
    checks++; if (sflag_a !== 1'b0 || nrnd_a !== 1'b1 || apple_a !== 8'h57) begin failures++; $display("FAIL place_occupied got=sf%b nr%b apple%h exp=sf0 nr1 apple57", sflag_a, nrnd_a, apple_a); end
    rnd_x = 4'hC; rnd_y = 4'd0; tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++; if (nrnd_a !== 1'b1 || apple_a !== 8'h57 || snake_a[7:0] !== 8'h57) begin failures++; $display("FAIL place_range got=nr%b apple%h head%h exp=nr1 apple57 head57", nrnd_a, apple_a, snake_a[7:0]); end
    rnd_x = 4'd0; rnd_y = 4'd0;
    @(negedge clk);
    rnd_x = 4'hF; rnd_y = 4'hF;
    checks++; if (apple_a !== 8'h00 || nrnd_a !== 1'b0) begin failures++; $display("FAIL place_accept got=apple%h nr%b exp=apple00 nr0", apple_a, nrnd_a); end
  endtask

  task automatic test_direction();
    press(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    checks++; if (snake_a[7:0] !== 8'h58) begin failures++; $display("FAIL reverse_rejected got=%h exp=58", snake_a[7:0]); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (snake_a[7:0] !== 8'h48) begin failures++; $display("FAIL turn_up got=%h exp=48", snake_a[7:0]); end
    @(negedge clk);
    right = 1'b1; tick = 1'b1;
    @(negedge clk);
    right = 1'b0; tick = 1'b0;
    checks++; if (snake_a[7:0] !== 8'h38) begin failures++; $display("FAIL press_in_tick got=%h exp=38", snake_a[7:0]); end
    step();
    checks++; if (snake_a[31:0] !== 32'h58483839) begin failures++; $display("FAIL press_next_tick got=%h exp=58483839", snake_a[31:0]); end
  endtask

  task automatic test_wall_wrap();
    apply_reset();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    offer(4'd0, 4'd0);
    step();
    step();
    checks++; if (snake_a[7:0] !== 8'h59 || snake_w[7:0] !== 8'h59) begin failures++; $display("FAIL edge_reach got=%h/%h exp=59/59", snake_a[7:0], snake_w[7:0]); end
    step();
    checks++; if (dead_a !== 1'b1) begin failures++; $display("FAIL wall_dead got=%b exp=1", dead_a); end
    checks++; if (snake_a[39:0] !== 40'hFF56575859) begin failures++; $display("FAIL wall_no_shift got=%h exp=FF56575859", snake_a[39:0]); end
    checks++; if (dead_w !== 1'b0 || snake_w[31:0] !== 32'h57585950) begin failures++; $display("FAIL wrap_move got=dead%b %h exp=dead0 57585950", dead_w, snake_w[31:0]); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checks++; if (dead_a !== 1'b1 || snake_a[39:0] !== 40'hFF56575859 || len_a !== 5'd4) begin failures++; $display("FAIL dead_frozen got=dead%b %h len%0d exp=dead1 FF56575859 len4", dead_a, snake_a[39:0], len_a); end
  endtask

  task automatic test_body_hit();
    apply_reset();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    offer(4'd9, 4'd5);
    checks++; if (apple_a !== 8'h59) begin failures++; $display("FAIL apple_59 got=%h exp=59", apple_a); end
    step();
    step();
    offer(4'd0, 4'd0);
    checks++; if (len_a !== 5'd5 || score_a !== 4'd2) begin failures++; $display("FAIL grow_5 got=len%0d score%0d exp=len5 score2", len_a, score_a); end
    press(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    press(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (dead_a !== 1'b1) begin failures++; $display("FAIL body_dead got=%b exp=1", dead_a); end
    checks++; if (snake_a[39:0] !== 40'h5758596968) begin failures++; $display("FAIL body_frozen got=%h exp=5758596968", snake_a[39:0]); end
  endtask

  task automatic test_tail_chase();
    apply_reset();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    offer(4'd0, 4'd0);
    press(1'b0, 1'b0, 1'b0, 1'b1);
    step();
    press(1'b0, 1'b0, 1'b1, 1'b0);
    step();
    press(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    checks++; if (dead_a !== 1'b0 || snake_a[39:0] !== 40'hFF57676656) begin failures++; $display("FAIL tail_chase got=dead%b %h exp=dead0 FF57676656", dead_a, snake_a[39:0]); end
    press(1'b0, 1'b1, 1'b0, 1'b0);
    step();
    checks++; if (dead_a !== 1'b0 || snake_a[31:0] !== 32'h67665657) begin failures++; $display("FAIL tail_chase2 got=dead%b %h exp=dead0 67665657", dead_a, snake_a[31:0]); end
  endtask

  task automatic test_win();
    apply_reset();
    press(1'b0, 1'b1, 1'b0, 1'b0);
    repeat (3) step();
    checks++; if (win_v !== 1'b1 || nrnd_v !== 1'b0) begin failures++; $display("FAIL win_flag got=win%b nr%b exp=win1 nr0", win_v, nrnd_v); end
    checks++; if (len_v !== 5'd4 || score_v !== 4'd1 || sflag_v !== 1'b1) begin failures++; $display("FAIL win_score got=len%0d score%0d sf%b exp=len4 score1 sf1", len_v, score_v, sflag_v); end
    checks++; if (win_a !== 1'b0) begin failures++; $display("FAIL nowin_default got=%b exp=0", win_a); end
    press(1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    checks++; if (snake_v !== 32'h54555657 || win_v !== 1'b1 || nrnd_v !== 1'b0 || sflag_v !== 1'b0) begin failures++; $display("FAIL win_frozen got=%h win%b nr%b sf%b exp=54555657 win1 nr0 sf0", snake_v, win_v, nrnd_v, sflag_v); end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_reset_mid_run();
    test_eat_place();
    test_direction();
    test_wall_wrap();
    test_body_hit();
    test_tail_chase();
    test_win();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
